guess_entry: RTL and testbench
==============================

# guess_entry

Accumulates debounced keypad presses into a multi-digit BCD guess for the guessing game. Sits directly downstream of the keypad decoder: consumes its 16-bit debounced `keys` vector and presents a completed guess to the game-logic comparator over a valid/ready handshake. Edge-detects presses, so each physical press registers exactly once however long the key is held.

## Interface
Parameters:
- `NUM_DIGITS`, default 2: maximum digits per guess, range 1–4.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `keys`  in  16: debounced key levels from the keypad decoder, same clock domain. Bit i is the key labelled hex i: 0–9 are digits, A is backspace, E is clear, F is enter; B, C and D are unused.
- `guess`  out  4*NUM_DIGITS: BCD guess with the newest digit in [3:0]. Unused upper digits are 0.
- `digit_count`  out  3: number of digits entered, 0..NUM_DIGITS.
- `guess_valid`  out  1: a guess is complete and held for the consumer.
- `guess_ready`  in  1: the consumer accepts the guess.
- `overflow`  out  1: sticky flag, set when a digit is pressed while the buffer is full.

## Operation
- Press detection:
  - `press = keys & ~keys_prev`, where `keys_prev` registers `keys` every cycle.
  - `keys_prev` resets to 16'hFFFF, so a key held through reset release is not counted.
  - A cycle with zero or more than one `press` bit set is a no-op; multi-key events are discarded entirely.
- State machine, two states:
  - ENTRY, the reset state.
  - HOLD.
- ENTRY, single press of a digit d (0–9):
  - If `digit_count < NUM_DIGITS`: `guess <= {guess[4*NUM_DIGITS-5:0], d}` and `digit_count` increments.
  - Otherwise `guess` and `digit_count` are unchanged and `overflow` is set.
- ENTRY, key A (backspace, only with the macro below):
  - If `digit_count > 0`: `guess <= guess >> 4` and `digit_count` decrements.
  - If `digit_count == 0`: no-op.
- ENTRY, key E (clear): `guess`, `digit_count` and `overflow` all go to 0.
- ENTRY, key F (enter):
  - If `digit_count > 0`: go to HOLD and assert `guess_valid`.
  - If `digit_count == 0`: ignored; stay in ENTRY.
- ENTRY, keys B, C, D: ignored.
- HOLD:
  - `guess` and `digit_count` are frozen.
  - All presses are ignored, including clear.
  - On a cycle where `guess_valid && guess_ready`: `guess`, `digit_count` and `overflow` go to 0, `guess_valid` deasserts, and the state returns to ENTRY.
  - Once asserted, `guess_valid` stays high until accepted.
- Reset, asynchronous and valid at any point including HOLD mid-handshake:
  - State ENTRY.
  - `guess` = 0, `digit_count` = 0, `guess_valid` = 0, `overflow` = 0.
  - `keys_prev` = 16'hFFFF.
  - Any pending guess is dropped.

## Timing
- All outputs are registered.
- A `keys` bit rising before clock edge k is acted on at edge k. Outputs reflect it after edge k (1-cycle latency).
- Enter detected at edge k: `guess_valid` is high from edge k.
- Accept: `guess_ready` high during the cycle before edge m gives `guess_valid` low and `guess` = 0 after edge m. The earliest new press is accepted at edge m+1, because presses in the accept cycle are ignored (still HOLD).
- If `guess_ready` is already high when enter registers, the guess is held exactly one cycle.
- A held key produces one press only. It must go low for at least one cycle and rise again to register another.
- Key release has no effect.

## Configuration
- `GUESS_ENTRY_BACKSPACE_EN`:
  - Defined: key A acts as backspace, as above.
  - Undefined: key A is treated like B, C and D (ignored), and the backspace shifter is not synthesized.

## Test plan
- Reset with key 5 held, release reset, hold 10 cycles → `digit_count` = 0 and `guess` = 0. Then release and re-press 5 → `guess` = 8'h05, `digit_count` = 1.
- NUM_DIGITS=2: press 4, 2, F with `guess_ready` = 0 → `guess` = 8'h42 and `guess_valid` = 1, held for 20 cycles. Pulse `guess_ready` → next cycle `guess_valid` = 0 and `guess` = 0.
- Press 1, 2, 3 → `guess` = 8'h12 and `overflow` = 1. Then E → `guess` = 0 and `overflow` = 0.
- Keys 3 and 7 rising in the same cycle → no change. F with `digit_count` = 0 → `guess_valid` stays 0.
- With macro: press 9, 8, A → `guess` = 8'h09, `digit_count` = 1. Without macro: same sequence → 8'h98.
- In HOLD, press 6 and E → `guess` unchanged. Assert `rst` low mid-HOLD → `guess_valid` = 0 immediately (asynchronous).

Source files
------------

// File: rtl/guess_entry.sv
// -----------------------------------------------------------------------------
// guess_entry
//
// Collects debounced keypad presses into a multi-digit BCD guess and hands
// the completed guess to the game-logic comparator over a valid/ready
// handshake. Each key press is edge-detected, so a held key is counted once.
//
// Key map (bit i of keys = key labelled hex i):
//   0-9 digit, A backspace (optional), E clear, F enter, B/C/D ignored.
//
// Optional feature macro: GUESS_ENTRY_BACKSPACE_EN
//   defined   -> key A removes the newest digit
//   undefined -> key A is ignored and no backspace shifter is built
//
// Parameters:
//   NUM_DIGITS   maximum digits per guess (1..4)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   keys         debounced key levels, same clock domain
//   guess        BCD guess, newest digit in [3:0], unused upper digits zero
//   digit_count  number of digits entered (0..NUM_DIGITS)
//   guess_valid  completed guess is held for the consumer
//   guess_ready  consumer accepts the guess
//   overflow     sticky: a digit was pressed while the buffer was full
// -----------------------------------------------------------------------------
module guess_entry #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               keys,
  output logic [4*NUM_DIGITS-1:0]   guess,
  output logic [2:0]                digit_count,
  output logic                      guess_valid,
  input  logic                      guess_ready,
  output logic                      overflow
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [0:0] {
    ST_ENTRY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   keys_prev_q;
  logic [W-1:0]  guess_q, guess_d;
  logic [2:0]    count_q, count_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;

  logic [15:0]   press_s;
  logic          single_s;
  logic [3:0]    key_idx_s;
  logic [W-1:0]  digit_ext_s;

  // Rising-edge detect; a press is acted on only when exactly one key rose.
  always_comb begin
    press_s  = keys & ~keys_prev_q;
    single_s = (press_s != 16'h0000) &&
               ((press_s & (press_s - 16'h0001)) == 16'h0000);
  end

  // Encode the single pressed key to its hex label.
  always_comb begin
    key_idx_s = 4'd0;
    for (int i = 0; i < 16; i++) begin
      key_idx_s = press_s[i] ? 4'(i) : key_idx_s;
    end
  end

  // Zero-extend the pressed digit to guess width (works for NUM_DIGITS = 1).
  always_comb begin
    digit_ext_s      = '0;
    digit_ext_s[3:0] = key_idx_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_ENTRY: begin
        if (single_s) begin
          case (key_idx_s)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
              if (count_q < 3'(NUM_DIGITS)) begin
                // Shifting left drops nothing useful: the top digit is
                // necessarily zero while the buffer is not full.
                guess_d = (guess_q << 4) | digit_ext_s;
                count_d = count_q + 3'd1;
              end else begin
                overflow_d = 1'b1;
              end
            end
`ifdef GUESS_ENTRY_BACKSPACE_EN
            4'hA: begin
              if (count_q != 3'd0) begin
                guess_d = guess_q >> 4;
                count_d = count_q - 3'd1;
              end else begin
                guess_d = guess_q;
              end
            end
`endif
            4'hE: begin
              guess_d    = '0;
              count_d    = 3'd0;
              overflow_d = 1'b0;
            end
            4'hF: begin
              if (count_q != 3'd0) begin
                state_d = ST_HOLD;
                valid_d = 1'b1;
              end else begin
                state_d = ST_ENTRY;
              end
            end
            default: begin
              state_d = ST_ENTRY;
            end
          endcase
        end else begin
          state_d = ST_ENTRY;
        end
      end

      ST_HOLD: begin
        // Guess is frozen and every key is ignored until the consumer takes it.
        if (valid_q && guess_ready) begin
          state_d    = ST_ENTRY;
          guess_d    = '0;
          count_d    = 3'd0;
          valid_d    = 1'b0;
          overflow_d = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d    = ST_ENTRY;
        guess_d    = '0;
        count_d    = 3'd0;
        valid_d    = 1'b0;
        overflow_d = 1'b0;
      end
    endcase
  end

  // State and output registers; keys_prev resets high so keys held through
  // reset release do not register as presses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ENTRY;
      keys_prev_q <= 16'hFFFF;
      guess_q     <= '0;
      count_q     <= 3'd0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      keys_prev_q <= keys;
      guess_q     <= guess_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign guess       = guess_q;
  assign digit_count = count_q;
  assign guess_valid = valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_guess_entry.sv
// -----------------------------------------------------------------------------
// tb_guess_entry
//
// Directed bench for guess_entry with NUM_DIGITS = 2. Inputs change and
// outputs are sampled on the falling clock edge. Expected values are hand
// computed; the backspace expectation follows GUESS_ENTRY_BACKSPACE_EN.
// -----------------------------------------------------------------------------
module tb_guess_entry;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  logic [7:0]  guess;
  logic [2:0]  digit_count;
  logic        guess_valid;
  logic        guess_ready;
  logic        overflow;

  int n_total;
  int n_bad;

  guess_entry #(.NUM_DIGITS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .keys        (keys),
    .guess       (guess),
    .digit_count (digit_count),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One press of key k: rise for one cycle, then release; returns at the
  // falling edge after the release edge.
  task automatic press(input int k);
    keys = 16'h0001 << k;
    @(negedge clk);
    keys = 16'h0000;
    @(negedge clk);
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b0;
    keys        = 16'h0020;     // key 5 held through reset
    guess_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_guess", 32'(guess), 32'h0);
    chk("rst_valid", 32'(guess_valid), 32'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("held5_count", 32'(digit_count), 32'h0);
    chk("held5_guess", 32'(guess), 32'h0);
    keys = 16'h0000;
    @(negedge clk);
    press(5);
    chk("repress5_guess", 32'(guess), 32'h05);
    chk("repress5_count", 32'(digit_count), 32'h1);
    press(14);
    chk("clr_guess", 32'(guess), 32'h0);

    // 4, 2, enter with consumer not ready
    press(4);
    press(2);
    press(15);
    chk("hold_guess", 32'(guess), 32'h42);
    chk("hold_valid", 32'(guess_valid), 32'h1);
    repeat (20) @(negedge clk);
    chk("hold20_guess", 32'(guess), 32'h42);
    chk("hold20_valid", 32'(guess_valid), 32'h1);
    chk("hold20_count", 32'(digit_count), 32'h2);
    // presses in HOLD are ignored, clear included
    press(6);
    press(14);
    chk("hold_ign_guess", 32'(guess), 32'h42);
    chk("hold_ign_count", 32'(digit_count), 32'h2);
    // accept, with key 7 rising in the accept cycle (must be ignored)
    guess_ready = 1'b1;
    keys        = 16'h0080;
    @(negedge clk);
    guess_ready = 1'b0;
    keys        = 16'h0000;
    chk("acc_valid", 32'(guess_valid), 32'h0);
    chk("acc_guess", 32'(guess), 32'h0);
    chk("acc_count", 32'(digit_count), 32'h0);
    @(negedge clk);
    chk("acc_key7_ign", 32'(digit_count), 32'h0);

    // overflow and clear
    press(1);
    press(2);
    press(3);
    chk("ovf_guess", 32'(guess), 32'h12);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(digit_count), 32'h2);
    press(14);
    chk("ovfclr_guess", 32'(guess), 32'h0);
    chk("ovfclr_flag", 32'(overflow), 32'h0);
    chk("ovfclr_count", 32'(digit_count), 32'h0);

    // two keys rising together, then enter with nothing entered
    keys = 16'h0088;
    @(negedge clk);
    keys = 16'h0000;
    chk("multi_count", 32'(digit_count), 32'h0);
    chk("multi_guess", 32'(guess), 32'h0);
    @(negedge clk);
    press(15);
    chk("empty_enter", 32'(guess_valid), 32'h0);

    // ignored keys B, C, D
    press(11);
    press(12);
    press(13);
    chk("bcd_ign", 32'(digit_count), 32'h0);

    // backspace
    press(9);
    press(8);
    press(10);
`ifdef GUESS_ENTRY_BACKSPACE_EN
    chk("bksp_guess", 32'(guess), 32'h09);
    chk("bksp_count", 32'(digit_count), 32'h1);
`else
    chk("bksp_guess", 32'(guess), 32'h98);
    chk("bksp_count", 32'(digit_count), 32'h2);
`endif
    press(14);

    // consumer already ready when enter registers: held exactly one cycle
    press(5);
    guess_ready = 1'b1;
    keys        = 16'h8000;
    @(negedge clk);
    keys = 16'h0000;
    chk("rdy_valid_hi", 32'(guess_valid), 32'h1);
    chk("rdy_guess", 32'(guess), 32'h05);
    @(negedge clk);
    chk("rdy_valid_lo", 32'(guess_valid), 32'h0);
    guess_ready = 1'b0;

    // asynchronous reset in the middle of HOLD
    press(3);
    press(15);
    chk("pre_rst_valid", 32'(guess_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(guess_valid), 32'h0);
    chk("async_rst_guess", 32'(guess), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(7);
    chk("post_rst_guess", 32'(guess), 32'h07);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
